kronos_spsram_arbiter: RTL and testbench
========================================

Name: kronos_spsram_arbiter

Overview:
- Shares one generic single-port 32-bit SRAM between two requesters:
  - port 0: instruction fetch, read-only.
  - port 1: data load/store, byte-masked.
- Round-robin arbitration, one access in flight at a time.
- Fixed 1-cycle ack latency; back-to-back issue to the other port in the same cycle one port is acked.
- Sits between the Kronos core's instr/data buses and the SRAM instance in the SoC.

Parameters:
- AWIDTH, 32, address width of both requester ports and the SRAM address port.

Ports:
- clk  in  1  system clock.
- rstz  in  1  asynchronous active-low reset.
- instr_addr  in  AWIDTH  fetch address.
- instr_req  in  1  fetch request; held with addr stable until instr_ack.
- instr_ack  out  1  fetch complete; instr_data valid this cycle.
- instr_data  out  32  fetch read data.
- data_addr  in  AWIDTH  load/store address.
- data_wdata  in  32  store data.
- data_mask  in  4  byte enables, bit i = byte i.
- data_wr_en  in  1  1 = store, 0 = load.
- data_req  in  1  load/store request; held with all fields stable until data_ack.
- data_ack  out  1  load/store complete; data_rdata valid this cycle when load.
- data_rdata  out  32  load read data.
- mem_addr  out  AWIDTH  to SRAM addr.
- mem_wdata  out  32  to SRAM wdata.
- mem_mask  out  4  to SRAM mask.
- mem_en  out  1  to SRAM en.
- mem_wr_en  out  1  to SRAM wr_en.
- mem_rdata  in  32  from SRAM rdata; valid one cycle after a read enable.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - rstz is asynchronous and active-low, resetting all state.
- State machine: IDLE, BUSY_I, BUSY_D. Registered; reset to IDLE.
- Acks:
  - instr_ack = (state==BUSY_I).
  - data_ack = (state==BUSY_D).
  - Both are 0 in reset and in IDLE.
- Read data:
  - instr_data and data_rdata are both driven with mem_rdata.
  - They are meaningful only while the corresponding ack is high.
  - data_rdata on a store-ack is don't-care.
- Candidate set each cycle:
  - instr_req, excluding port 0 if instr_ack is high this cycle.
  - data_req, excluding port 1 if data_ack is high this cycle.
- Arbitration:
  - One candidate: it wins.
  - Both candidates: the port not granted last wins.
  - Last-granted pointer resets to "data", so port 0 wins the first contention after reset.
  - The pointer updates only on a launch.
- Launch (any candidate exists):
  - mem_en=1 combinationally this cycle.
  - mem_addr, mem_wdata, mem_mask and mem_wr_en are taken from the winner.
  - Port 0 launch forces mem_wr_en=0, mem_mask=4'hF, mem_wdata=0.
  - Next state is BUSY_I or BUSY_D for the winner.
- No candidate: mem_en=0 and next state IDLE.
- mem_* outputs when mem_en=0:
  - mem_wr_en=0 and mem_mask=0.
  - addr/wdata hold the data-port value (don't-care).
- Latency:
  - Ack arrives exactly 1 cycle after launch, for both reads and writes.
  - Minimum request-to-ack is 1 cycle if granted immediately.
- Throughput:
  - Port A's ack cycle may launch port B, so continuous alternation gives one access per cycle.
  - A single port requesting alone gets one access every 2 cycles, because it is excluded in its own ack cycle.
- Requester rules:
  - Deassert req or present a new transaction in the cycle after ack.
  - A req still high in the cycle after ack is treated as a new request.
- Reset during BUSY_x:
  - The access is abandoned and no ack is produced.
  - A store launched before reset may already be written; no rollback.
- Address bits passed unmodified; the SRAM ignores addr[1:0].

Test Plan:
- Reset, then single fetch: instr_addr=0x10, instr_req=1, SRAM word 4 = 0xDEADBEEF.
  - Cycle 0: mem_en=1, mem_wr_en=0, mem_addr=0x10.
  - Cycle 1: instr_ack=1, instr_data=0xDEADBEEF, data_ack=0.
- Masked store then load: data store addr=0x20, wdata=0x11223344, mask=4'b0101 onto word 0xFFFFFFFF.
  - Store acked after 1 cycle.
  - Subsequent load of 0x20 returns 0xFF22FF44.
- Simultaneous first requests after reset (instr 0x0, data load 0x40).
  - Port 0 launches at cycle 0 and is acked at cycle 1.
  - Port 1 launches at cycle 1 and is acked at cycle 2.
- Both requesting continuously for 20 cycles.
  - Grants strictly alternate I,D,I,D…, with one ack every cycle from cycle 1 on.
  - No port waits more than 2 cycles for a grant.
- Data-only stream of 4 loads (req re-raised after each ack).
  - Acks at cycles 1,3,5,7; mem_en=0 in ack cycles when no other request.
- rstz pulled low in a BUSY_D cycle for a load.
  - No data_ack; state IDLE; all acks 0 during reset.
  - A new fetch after release completes normally with 1-cycle latency.

Source files
------------

// File: rtl/kronos_spsram_arbiter.sv
// kronos_spsram_arbiter
// Shares one single-port 32-bit SRAM between the Kronos instruction-fetch
// port (read-only) and the data load/store port (byte-masked). One access is
// in flight at a time. Every access is acked exactly one cycle after it is
// launched. Contention is resolved round-robin. A port that is being acked
// this cycle is not a candidate this cycle, so the other port can launch in
// that same cycle and alternating traffic reaches one access per cycle.

`timescale 1ns/1ps

module kronos_spsram_arbiter #(
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstz,

    // instruction fetch port (read-only)
    input  logic [AWIDTH-1:0] instr_addr,
    input  logic              instr_req,
    output logic              instr_ack,
    output logic [31:0]       instr_data,

    // data load/store port
    input  logic [AWIDTH-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_mask,
    input  logic              data_wr_en,
    input  logic              data_req,
    output logic              data_ack,
    output logic [31:0]       data_rdata,

    // SRAM side
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    output logic              mem_en,
    output logic              mem_wr_en,
    input  logic [31:0]       mem_rdata
);

    // ------------------------------------------------------------------
    // State encoding. BUSY_x means an access for port x was launched in
    // the previous cycle and is being acked in the current cycle.
    // ------------------------------------------------------------------
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Round-robin pointer: 1 = data port was granted last, 0 = fetch port.
    logic       last_grant_d;

    // Candidate and grant terms for the current cycle.
    logic       cand_i;
    logic       cand_d;
    logic       grant_i;
    logic       grant_d;
    logic       launch;

    // ------------------------------------------------------------------
    // Acks depend on the registered state only, so they never combine
    // with the incoming request lines.
    // ------------------------------------------------------------------
    assign instr_ack = (state == BUSY_I);
    assign data_ack  = (state == BUSY_D);

    // The SRAM read data is routed to both ports. Each port qualifies it
    // with its own ack.
    assign instr_data = mem_rdata;
    assign data_rdata = mem_rdata;

    // Candidate selection and round-robin arbitration for this cycle.
    always_comb begin
        // A port that is being acked this cycle is excluded. A request it
        // still holds is the tail of the transaction that just completed.
        cand_i  = instr_req & ~instr_ack;
        cand_d  = data_req  & ~data_ack;

        // On contention, the port that was not granted last wins.
        grant_i = cand_i & (~cand_d | last_grant_d);
        grant_d = cand_d & ~grant_i;
        launch  = grant_i | grant_d;
    end

    // SRAM command mux: drive the winner's fields when launching.
    always_comb begin
        // NOTE: every output gets a default before any branch. Without
        // defaults, a path that skips an assignment infers a latch.
        mem_en    = launch;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        mem_mask  = 4'h0;
        mem_wr_en = 1'b0;

        if (grant_i) begin
            // A fetch is always a full-word read.
            mem_addr  = instr_addr;
            mem_wdata = 32'h0;
            mem_mask  = 4'hF;
            mem_wr_en = 1'b0;
        end else if (grant_d) begin
            mem_mask  = data_mask;
            mem_wr_en = data_wr_en;
        end
    end

    // Next-state selection: follow the winner, otherwise go idle.
    always_comb begin
        state_nxt = IDLE;
        if (grant_i) begin
            state_nxt = BUSY_I;
        end else if (grant_d) begin
            state_nxt = BUSY_D;
        end
    end

    // State register. Reset abandons any access in flight and drops its ack.
    always_ff @(posedge clk or negedge rstz) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples pre-edge values regardless of block order.
        if (!rstz) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer. It moves only when an access is launched, and it
    // resets to "data" so the fetch port wins the first contention.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            last_grant_d <= 1'b1;
        end else if (launch) begin
            last_grant_d <= grant_d;
        end
    end

    // ------------------------------------------------------------------
    // Structural invariants (ignored by synthesis).
    // ------------------------------------------------------------------

    // Only one access can be acked in a given cycle.
    a_single_ack : assert property (
        @(posedge clk) disable iff (!rstz) !(instr_ack && data_ack)
    );

    // The state register never takes the unused encoding.
    a_legal_state : assert property (
        @(posedge clk) disable iff (!rstz) (state != 2'd3)
    );

    // A fetch launch is never a write.
    a_fetch_is_read : assert property (
        @(posedge clk) disable iff (!rstz) (grant_i |-> !mem_wr_en)
    );

endmodule

// File: tb/tb_kronos_spsram_arbiter.sv
// tb_kronos_spsram_arbiter
// Self-checking bench for kronos_spsram_arbiter. A behavioural SRAM sits on
// the memory side. Directed scenarios cover reset, latency, masking,
// contention and reset during an access. A randomized run is compared with a
// transaction-level reference model of the arbitration rules and a reference
// memory image.

`timescale 1ns/1ps

module tb_kronos_spsram_arbiter;

    localparam int AWIDTH = 32;

    logic              clk = 1'b0;
    logic              rstz;
    logic [AWIDTH-1:0] instr_addr;
    logic              instr_req;
    logic              instr_ack;
    logic [31:0]       instr_data;
    logic [AWIDTH-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_mask;
    logic              data_wr_en;
    logic              data_req;
    logic              data_ack;
    logic [31:0]       data_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_mask;
    logic              mem_en;
    logic              mem_wr_en;
    logic [31:0]       mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // The behavioural SRAM, its bench-side preload port, and the reference image.
    logic [31:0] sram [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_val = 32'h0;

    always #5 clk = ~clk;

    kronos_spsram_arbiter #(.AWIDTH(AWIDTH)) dut (
        .clk        (clk),
        .rstz       (rstz),
        .instr_addr (instr_addr),
        .instr_req  (instr_req),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_mask  (data_mask),
        .data_wr_en (data_wr_en),
        .data_req   (data_req),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_rdata  (mem_rdata)
    );

    // Single-port SRAM: byte-masked write, read data valid the cycle after.
    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_idx] <= pl_val;
        end else if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[9:2]];
            end
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Writes one SRAM word and the reference image. The DUT must be idle.
    task automatic preload(input int idx, input logic [31:0] v);
        pl_idx      = idx[7:0];
        pl_val      = v;
        pl_en       = 1'b1;
        ref_mem[idx] = v;
        tick();
        pl_en       = 1'b0;
    endtask

    task automatic idle_inputs;
        instr_req  = 1'b0;
        data_req   = 1'b0;
        instr_addr = '0;
        data_addr  = '0;
        data_wdata = '0;
        data_mask  = 4'h0;
        data_wr_en = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rstz = 1'b0;
        tick();
        @(negedge clk);
        rstz = 1'b1;
        tick();
    endtask

    // Reset state: no acks and no SRAM activity while in reset and idle.
    task automatic test_reset;
        idle_inputs();
        rstz = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (instr_ack !== 1'b0) begin n_errors++; $display("FAIL reset_instr_ack: got %b want 0", instr_ack); end
        n_checks++; if (data_ack !== 1'b0) begin n_errors++; $display("FAIL reset_data_ack: got %b want 0", data_ack); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_mem_wr_en: got %b want 0", mem_wr_en); end
        n_checks++; if (mem_mask !== 4'h0) begin n_errors++; $display("FAIL reset_mem_mask: got %h want 0", mem_mask); end
        rstz = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (instr_ack !== 1'b0 || data_ack !== 1'b0) begin n_errors++; $display("FAIL idle_acks: got %b%b want 00", instr_ack, data_ack); end
        tick();
    endtask

    // Single fetch: launch in cycle 0, ack with data in cycle 1.
    task automatic test_single_fetch;
        preload(4, 32'hDEADBEEF);
        instr_addr = 32'h10;
        instr_req  = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL fetch_c0_mem_en: got %b want 1", mem_en); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_errors++; $display("FAIL fetch_c0_wr_en: got %b want 0", mem_wr_en); end
        n_checks++; if (mem_addr !== 32'h10) begin n_errors++; $display("FAIL fetch_c0_addr: got %h want 10", mem_addr); end
        n_checks++; if (mem_mask !== 4'hF) begin n_errors++; $display("FAIL fetch_c0_mask: got %h want f", mem_mask); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_errors++; $display("FAIL fetch_c0_wdata: got %h want 0", mem_wdata); end
        tick();
        @(negedge clk);
        n_checks++; if (instr_ack !== 1'b1) begin n_errors++; $display("FAIL fetch_c1_ack: got %b want 1", instr_ack); end
        n_checks++; if (instr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL fetch_c1_data: got %h want deadbeef", instr_data); end
        n_checks++; if (data_ack !== 1'b0) begin n_errors++; $display("FAIL fetch_c1_data_ack: got %b want 0", data_ack); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL fetch_c1_excluded: got mem_en %b want 0", mem_en); end
        tick();
        instr_req = 1'b0;
        @(negedge clk);
        n_checks++; if (instr_ack !== 1'b0) begin n_errors++; $display("FAIL fetch_c2_ack: got %b want 0", instr_ack); end
        tick();
    endtask

    // Masked store onto 0xFFFFFFFF, then a load of the same word.
    task automatic test_masked_store;
        preload(8, 32'hFFFFFFFF);
        data_addr  = 32'h20;
        data_wdata = 32'h11223344;
        data_mask  = 4'b0101;
        data_wr_en = 1'b1;
        data_req   = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_wr_en !== 1'b1) begin n_errors++; $display("FAIL store_c0_en: got en=%b wr=%b want 1 1", mem_en, mem_wr_en); end
        n_checks++; if (mem_mask !== 4'b0101) begin n_errors++; $display("FAIL store_c0_mask: got %h want 5", mem_mask); end
        n_checks++; if (mem_wdata !== 32'h11223344) begin n_errors++; $display("FAIL store_c0_wdata: got %h want 11223344", mem_wdata); end
        n_checks++; if (mem_addr !== 32'h20) begin n_errors++; $display("FAIL store_c0_addr: got %h want 20", mem_addr); end
        tick();
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b1) begin n_errors++; $display("FAIL store_c1_ack: got %b want 1", data_ack); end
        n_checks++; if (instr_ack !== 1'b0) begin n_errors++; $display("FAIL store_c1_instr_ack: got %b want 0", instr_ack); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL store_c1_excluded: got mem_en %b want 0", mem_en); end
        tick();
        data_wr_en = 1'b0;
        data_mask  = 4'hF;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_wr_en !== 1'b0) begin n_errors++; $display("FAIL load_c0_en: got en=%b wr=%b want 1 0", mem_en, mem_wr_en); end
        tick();
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b1) begin n_errors++; $display("FAIL load_c1_ack: got %b want 1", data_ack); end
        n_checks++; if (data_rdata !== 32'hFF22FF44) begin n_errors++; $display("FAIL load_c1_rdata: got %h want ff22ff44", data_rdata); end
        tick();
        data_req   = 1'b0;
        ref_mem[8] = 32'hFF22FF44;
    endtask

    // First contention after reset: fetch wins, data follows in the ack cycle.
    task automatic test_simultaneous;
        do_reset();
        preload(0, 32'hA5A50000);
        preload(16, 32'h0000C3C3);
        instr_addr = 32'h0;
        instr_req  = 1'b1;
        data_addr  = 32'h40;
        data_wr_en = 1'b0;
        data_mask  = 4'hF;
        data_req   = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0 || mem_wr_en !== 1'b0) begin n_errors++; $display("FAIL sim_c0_grant: got en=%b addr=%h wr=%b want 1 0 0", mem_en, mem_addr, mem_wr_en); end
        n_checks++; if (instr_ack !== 1'b0 || data_ack !== 1'b0) begin n_errors++; $display("FAIL sim_c0_acks: got %b%b want 00", instr_ack, data_ack); end
        tick();
        @(negedge clk);
        n_checks++; if (instr_ack !== 1'b1 || data_ack !== 1'b0) begin n_errors++; $display("FAIL sim_c1_acks: got i=%b d=%b want 1 0", instr_ack, data_ack); end
        n_checks++; if (instr_data !== 32'hA5A50000) begin n_errors++; $display("FAIL sim_c1_data: got %h want a5a50000", instr_data); end
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin n_errors++; $display("FAIL sim_c1_grant_d: got en=%b addr=%h want 1 40", mem_en, mem_addr); end
        tick();
        instr_req = 1'b0;
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b1 || instr_ack !== 1'b0) begin n_errors++; $display("FAIL sim_c2_acks: got i=%b d=%b want 0 1", instr_ack, data_ack); end
        n_checks++; if (data_rdata !== 32'h0000C3C3) begin n_errors++; $display("FAIL sim_c2_rdata: got %h want 0000c3c3", data_rdata); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL sim_c2_mem_en: got %b want 0", mem_en); end
        tick();
        data_req = 1'b0;
    endtask

    // Both ports requesting for 20 cycles: strict I,D alternation.
    task automatic test_back_to_back;
        int last_i;
        int last_d;
        logic [31:0] v_i;
        logic [31:0] v_d;
        v_i = $urandom;
        v_d = $urandom;
        preload(2, v_i);
        preload(17, v_d);
        last_i = 0;
        last_d = 0;
        instr_addr = 32'h8;
        instr_req  = 1'b1;
        data_addr  = 32'h44;
        data_wr_en = 1'b0;
        data_mask  = 4'hF;
        data_req   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL b2b_mem_en k=%0d: got %b want 1", k, mem_en); end
            n_checks++; if (mem_addr !== ((k % 2 == 0) ? 32'h8 : 32'h44)) begin n_errors++; $display("FAIL b2b_grant k=%0d: got addr %h want %h", k, mem_addr, (k % 2 == 0) ? 32'h8 : 32'h44); end
            if (mem_addr === 32'h8) begin
                n_checks++; if (k - last_i > 2) begin n_errors++; $display("FAIL b2b_wait_i k=%0d: got wait %0d want <=2", k, k - last_i); end
                last_i = k;
            end else if (mem_addr === 32'h44) begin
                n_checks++; if (k - last_d > 2) begin n_errors++; $display("FAIL b2b_wait_d k=%0d: got wait %0d want <=2", k, k - last_d); end
                last_d = k;
            end
            if (k >= 1) begin
                n_checks++; if (instr_ack !== (k % 2 == 1) || data_ack !== (k % 2 == 0)) begin n_errors++; $display("FAIL b2b_acks k=%0d: got i=%b d=%b want %b %b", k, instr_ack, data_ack, (k % 2 == 1), (k % 2 == 0)); end
                if (k % 2 == 1) begin
                    n_checks++; if (instr_data !== v_i) begin n_errors++; $display("FAIL b2b_idata k=%0d: got %h want %h", k, instr_data, v_i); end
                end else begin
                    n_checks++; if (data_rdata !== v_d) begin n_errors++; $display("FAIL b2b_drdata k=%0d: got %h want %h", k, data_rdata, v_d); end
                end
            end
            tick();
        end
        instr_req = 1'b0;
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b1 || data_rdata !== v_d) begin n_errors++; $display("FAIL b2b_tail: got ack=%b rdata=%h want 1 %h", data_ack, data_rdata, v_d); end
        n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL b2b_tail_mem_en: got %b want 0", mem_en); end
        tick();
        data_req = 1'b0;
    endtask

    // Data port alone: one access every 2 cycles, acks at 1,3,5,7.
    task automatic test_data_stream;
        logic [31:0] vals [4];
        for (int n = 0; n < 4; n++) begin
            vals[n] = $urandom;
            preload(32 + n, vals[n]);
        end
        data_addr  = 32'h80;
        data_wr_en = 1'b0;
        data_mask  = 4'hF;
        data_req   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80 + 32'(4 * (k / 2))) begin n_errors++; $display("FAIL stream_launch k=%0d: got en=%b addr=%h want 1 %h", k, mem_en, mem_addr, 32'h80 + 32'(4 * (k / 2))); end
                n_checks++; if (data_ack !== 1'b0) begin n_errors++; $display("FAIL stream_noack k=%0d: got %b want 0", k, data_ack); end
            end else begin
                n_checks++; if (data_ack !== 1'b1) begin n_errors++; $display("FAIL stream_ack k=%0d: got %b want 1", k, data_ack); end
                n_checks++; if (data_rdata !== vals[k / 2]) begin n_errors++; $display("FAIL stream_rdata k=%0d: got %h want %h", k, data_rdata, vals[k / 2]); end
                n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL stream_ack_mem_en k=%0d: got %b want 0", k, mem_en); end
            end
            tick();
            if (k % 2 == 1) data_addr = 32'h80 + 32'(4 * ((k + 1) / 2));
        end
        data_req = 1'b0;
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b0 || mem_en !== 1'b0) begin n_errors++; $display("FAIL stream_end: got ack=%b en=%b want 0 0", data_ack, mem_en); end
        tick();
    endtask

    // Reset while a load is in BUSY_D: no ack, then a clean fetch.
    task automatic test_reset_busy;
        data_addr  = 32'h40;
        data_wr_en = 1'b0;
        data_mask  = 4'hF;
        data_req   = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1) begin n_errors++; $display("FAIL rbusy_launch: got %b want 1", mem_en); end
        tick();
        rstz     = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b0 || instr_ack !== 1'b0) begin n_errors++; $display("FAIL rbusy_in_reset: got i=%b d=%b want 0 0", instr_ack, data_ack); end
        tick();
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b0 || instr_ack !== 1'b0 || mem_en !== 1'b0) begin n_errors++; $display("FAIL rbusy_held: got i=%b d=%b en=%b want 0 0 0", instr_ack, data_ack, mem_en); end
        rstz = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (data_ack !== 1'b0) begin n_errors++; $display("FAIL rbusy_late_ack: got %b want 0", data_ack); end
        tick();
        instr_addr = 32'h10;
        instr_req  = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || instr_ack !== 1'b0) begin n_errors++; $display("FAIL rbusy_fetch_c0: got en=%b addr=%h ack=%b want 1 10 0", mem_en, mem_addr, instr_ack); end
        tick();
        @(negedge clk);
        n_checks++; if (instr_ack !== 1'b1 || instr_data !== 32'hDEADBEEF || data_ack !== 1'b0) begin n_errors++; $display("FAIL rbusy_fetch_c1: got ack=%b data=%h dack=%b want 1 deadbeef 0", instr_ack, instr_data, data_ack); end
        tick();
        instr_req = 1'b0;
    endtask

    // Randomized traffic against a transaction-level reference model.
    task automatic test_random(input int n_cycles);
        int          busy;       // 0 none, 1 fetch acks now, 2 data acks now
        bit          prefer_i;   // which port wins the next contention
        bit          i_act, d_act;
        logic [31:0] i_a, d_a, d_wd, f_a, f_wd;
        logic [3:0]  d_m, f_m;
        bit          d_w, f_w;
        bit          exp_iack, exp_dack, ci, cd, drain;
        int          win;
        do_reset();
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        busy = 0; prefer_i = 1'b1;
        i_act = 1'b0; d_act = 1'b0;
        i_a = '0; d_a = '0; d_wd = '0; d_m = '0; d_w = 1'b0;
        f_a = '0; f_wd = '0; f_m = '0; f_w = 1'b0;
        for (int cyc = 0; cyc < n_cycles + 8; cyc++) begin
            drain = (cyc >= n_cycles);
            instr_req = i_act; instr_addr = i_a;
            data_req = d_act; data_addr = d_a; data_wdata = d_wd; data_mask = d_m; data_wr_en = d_w;
            @(negedge clk);
            exp_iack = (busy == 1);
            exp_dack = (busy == 2);
            n_checks++; if (instr_ack !== exp_iack || data_ack !== exp_dack) begin n_errors++; $display("FAIL rnd_acks cyc=%0d: got i=%b d=%b want %b %b", cyc, instr_ack, data_ack, exp_iack, exp_dack); end
            if (exp_iack) begin
                n_checks++; if (instr_data !== ref_mem[f_a[9:2]]) begin n_errors++; $display("FAIL rnd_idata cyc=%0d: got %h want %h", cyc, instr_data, ref_mem[f_a[9:2]]); end
            end
            if (exp_dack) begin
                if (f_w) begin
                    for (int b = 0; b < 4; b++)
                        if (f_m[b]) ref_mem[f_a[9:2]][8*b +: 8] = f_wd[8*b +: 8];
                end else begin
                    n_checks++; if (data_rdata !== ref_mem[f_a[9:2]]) begin n_errors++; $display("FAIL rnd_drdata cyc=%0d: got %h want %h", cyc, data_rdata, ref_mem[f_a[9:2]]); end
                end
            end
            ci = i_act && !exp_iack;
            cd = d_act && !exp_dack;
            if (ci && cd) win = prefer_i ? 1 : 2;
            else if (ci) win = 1;
            else if (cd) win = 2;
            else win = 0;
            n_checks++; if (mem_en !== (win != 0)) begin n_errors++; $display("FAIL rnd_mem_en cyc=%0d: got %b want %b", cyc, mem_en, (win != 0)); end
            if (win == 1) begin
                n_checks++; if (mem_addr !== i_a || mem_wr_en !== 1'b0 || mem_mask !== 4'hF || mem_wdata !== 32'h0) begin n_errors++; $display("FAIL rnd_fetch cyc=%0d: got a=%h w=%b m=%h d=%h want %h 0 f 0", cyc, mem_addr, mem_wr_en, mem_mask, mem_wdata, i_a); end
                f_a = i_a; f_w = 1'b0; f_m = 4'hF; f_wd = '0;
                prefer_i = 1'b0;
            end else if (win == 2) begin
                n_checks++; if (mem_addr !== d_a || mem_wr_en !== d_w || mem_mask !== d_m || mem_wdata !== d_wd) begin n_errors++; $display("FAIL rnd_data cyc=%0d: got a=%h w=%b m=%h d=%h want %h %b %h %h", cyc, mem_addr, mem_wr_en, mem_mask, mem_wdata, d_a, d_w, d_m, d_wd); end
                f_a = d_a; f_w = d_w; f_m = d_m; f_wd = d_wd;
                prefer_i = 1'b1;
            end else begin
                n_checks++; if (mem_wr_en !== 1'b0 || mem_mask !== 4'h0) begin n_errors++; $display("FAIL rnd_idle cyc=%0d: got w=%b m=%h want 0 0", cyc, mem_wr_en, mem_mask); end
            end
            busy = win;
            // Requesters: hold until acked, then idle or start a new transaction.
            if (exp_iack || !i_act) begin
                i_act = !drain && ($urandom_range(0, 3) != 0);
                i_a   = $urandom;
            end
            if (exp_dack || !d_act) begin
                d_act = !drain && ($urandom_range(0, 3) != 0);
                d_a   = $urandom;
                d_wd  = $urandom;
                d_m   = 4'($urandom);
                d_w   = 1'($urandom);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rstz = 1'b0;
        test_reset();
        test_single_fetch();
        test_masked_store();
        test_simultaneous();
        test_back_to_back();
        test_data_stream();
        test_reset_busy();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
